// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - APB initiator bridging a valid/ready command channel to one APB transfer
// Single outstanding SETUP->ACCESS transfer with a wait-state timeout and a held response.
module apb_master_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_write,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [DATA_W-1:0] i_cmd_wdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              o_rsp_timeout,
  output logic [ADDR_W-1:0] o_paddr,
  output logic              o_wr_en,
  output logic              o_psel,
  output logic              o_pen,
  output logic [DATA_W-1:0] o_pwdata,
  input  logic [DATA_W-1:0] i_prdata,
  input  logic              i_pready,
  input  logic              i_pselverr
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t             r_state, w_state;
  logic [ADDR_W-1:0]  r_paddr, w_paddr;
  logic [DATA_W-1:0]  r_pwdata, w_pwdata;
  logic               r_wr_en, w_wr_en;
  logic               r_psel, w_psel;
  logic               r_pen, w_pen;
  logic               r_rsp_valid, w_rsp_valid;
  logic               r_rsp_err, w_rsp_err;
  logic               r_rsp_to, w_rsp_to;
  logic [DATA_W-1:0]  r_rsp_rdata, w_rsp_rdata;
  logic [CNT_W-1:0]   r_cnt, w_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_wr_en     <= 1'b0;
      r_psel      <= 1'b0;
      r_pen       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_to    <= 1'b0;
      r_rsp_rdata <= '0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state;
      r_paddr     <= w_paddr;
      r_pwdata    <= w_pwdata;
      r_wr_en     <= w_wr_en;
      r_psel      <= w_psel;
      r_pen       <= w_pen;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_err   <= w_rsp_err;
      r_rsp_to    <= w_rsp_to;
      r_rsp_rdata <= w_rsp_rdata;
      r_cnt       <= w_cnt;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_paddr     = r_paddr;
    w_pwdata    = r_pwdata;
    w_wr_en     = r_wr_en;
    w_psel      = r_psel;
    w_pen       = r_pen;
    w_rsp_valid = r_rsp_valid;
    w_rsp_err   = r_rsp_err;
    w_rsp_to    = r_rsp_to;
    w_rsp_rdata = r_rsp_rdata;
    w_cnt       = r_cnt;
    case (r_state)
      IDLE: begin
        if (i_cmd_valid) begin
          w_paddr  = i_cmd_addr;
          w_pwdata = i_cmd_wdata;
          w_wr_en  = i_cmd_write;
          w_psel   = 1'b1;
          w_pen    = 1'b0;
          w_state  = SETUP;
        end
      end
      SETUP: begin
        w_pen   = 1'b1;
        w_cnt   = '0;
        w_state = ACCESS;
      end
      ACCESS: begin
        // pready is checked first so a response on the last allowed cycle still completes
        if (i_pready) begin
          w_psel      = 1'b0;
          w_pen       = 1'b0;
          w_rsp_valid = 1'b1;
          w_rsp_err   = i_pselverr;
          w_rsp_to    = 1'b0;
          w_rsp_rdata = (!r_wr_en && !i_pselverr) ? i_prdata : '0;
          w_state     = RESP;
        end else if (r_cnt == CNT_LAST) begin
          w_psel      = 1'b0;
          w_pen       = 1'b0;
          w_rsp_valid = 1'b1;
          w_rsp_err   = 1'b1;
          w_rsp_to    = 1'b1;
          w_rsp_rdata = '0;
          w_state     = RESP;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      RESP: begin
        if (i_rsp_ready) begin
          w_rsp_valid = 1'b0;
          w_rsp_err   = 1'b0;
          w_rsp_to    = 1'b0;
          w_state     = IDLE;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  assign o_cmd_ready   = (r_state == IDLE);
  assign o_rsp_valid   = r_rsp_valid;
  assign o_rsp_rdata   = r_rsp_rdata;
  assign o_rsp_err     = r_rsp_err;
  assign o_rsp_timeout = r_rsp_to;
  assign o_paddr       = r_paddr;
  assign o_wr_en       = r_wr_en;
  assign o_psel        = r_psel;
  assign o_pen         = r_pen;
  assign o_pwdata      = r_pwdata;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - scoreboard bench for apb_master_bridge
// Stimulus pushes expected responses; a negedge monitor pops them on each response handshake.
module tb_apb_master_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [31:0] paddr;
  logic        wr_en;
  logic        psel;
  logic        pen;
  logic [31:0] pwdata;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0;
  logic        pselverr = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        to;
  } exp_t;
  exp_t exp_q[$];

  int          cfg_waits  = 0;
  logic [31:0] cfg_prdata = '0;
  logic        cfg_err    = 1'b0;

  always #5 clk = ~clk;

  apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
    .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata),
    .o_rsp_err(rsp_err), .o_rsp_timeout(rsp_timeout),
    .o_paddr(paddr), .o_wr_en(wr_en), .o_psel(psel), .o_pen(pen), .o_pwdata(pwdata),
    .i_prdata(prdata), .i_pready(pready), .i_pselverr(pselverr)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Responder: inserts cfg_waits wait states in ACCESS; pready is deliberately high outside ACCESS
  initial begin
    int wcnt;
    wcnt = 0;
    forever begin
      @(posedge clk);
      #2;
      if (psel && pen) begin
        if (wcnt == cfg_waits) begin
          pready = 1'b1; prdata = cfg_prdata; pselverr = cfg_err;
        end else begin
          pready = 1'b0; prdata = 32'hFFFF_FFFF; pselverr = 1'b1;
        end
        wcnt++;
      end else begin
        pready = 1'b1; prdata = 32'hA5A5_A5A5; pselverr = 1'b1; wcnt = 0;
      end
    end
  end

  initial begin
    exp_t        e;
    logic        pv, phs, perr, pto;
    logic [31:0] prd;
    pv = 1'b0; phs = 1'b0; perr = 1'b0; pto = 1'b0; prd = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rsp_valid && pv && !phs) begin
          chk("rsp_stable_rdata", 64'(rsp_rdata), 64'(prd));
          chk("rsp_stable_err", 64'({rsp_err, rsp_timeout}), 64'({perr, pto}));
        end
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_rsp", 64'(1), 64'(0));
          end else begin
            e = exp_q.pop_front();
            chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
            chk("rsp_err", 64'(rsp_err), 64'(e.err));
            chk("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
          end
        end
      end
      pv = rsp_valid; phs = rsp_valid && rsp_ready;
      prd = rsp_rdata; perr = rsp_err; pto = rsp_timeout;
    end
  end

  task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int waits, input logic perr, input logic [31:0] prd,
                         input logic [31:0] exp_rd, input logic exp_err, input logic exp_to,
                         input int exp_lat, input int hold);
    int   lat, n_psel, n_pen;
    logic addr_ok;
    cfg_waits = waits; cfg_prdata = prd; cfg_err = perr;
    exp_q.push_back({exp_rd, exp_err, exp_to});
    chk("cmd_ready_idle", 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_addr = 32'h0BAD_0BAD; cmd_wdata = 32'h0BAD_0BAD; cmd_write = ~wr;
    lat = 0; n_psel = 0; n_pen = 0; addr_ok = 1'b1;
    while (!rsp_valid && lat < 50) begin
      if (psel) n_psel++;
      if (pen) n_pen++;
      if (paddr !== addr || pwdata !== wdata || wr_en !== wr) addr_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    chk("rsp_latency", 64'(lat), 64'(exp_lat));
    chk("psel_cycles", 64'(n_psel), 64'(exp_lat));
    chk("pen_cycles", 64'(n_pen), 64'(exp_lat - 1));
    chk("bus_stable", 64'(addr_ok), 64'(1));
    chk("bus_idle_in_resp", 64'({psel, pen}), 64'(0));
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1;
      chk("cmd_ready_in_resp", 64'(cmd_ready), 64'(0));
      chk("psel_in_resp", 64'(psel), 64'(0));
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0; cmd_valid = 1'b0;
    chk("rsp_valid_cleared", 64'({rsp_valid, rsp_err, rsp_timeout}), 64'(0));
    chk("paddr_held", 64'(paddr), 64'(addr));
  endtask

  initial begin
    logic any_valid;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctrl", 64'({cmd_ready, psel, pen, wr_en, rsp_valid, rsp_err, rsp_timeout}),
        64'(7'b1000000));
    chk("reset_paddr", 64'(paddr), 64'(0));
    chk("reset_pwdata", 64'(pwdata), 64'(0));
    chk("reset_rdata", 64'(rsp_rdata), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    do_xfer(1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0, 32'h1111_1111, 32'h0, 1'b0, 1'b0, 2, 0);
    do_xfer(1'b0, 32'h10, 32'h0, 3, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 5, 0);
    do_xfer(1'b0, 32'h20, 32'h0, 0, 1'b1, 32'h1234_5678, 32'h0, 1'b1, 1'b0, 2, 0);
    do_xfer(1'b1, 32'h24, 32'h0F0F_0F0F, 1, 1'b1, 32'h1234_5678, 32'h0, 1'b1, 1'b0, 3, 0);
    do_xfer(1'b0, 32'h30, 32'h0, 100, 1'b0, 32'h7777_7777, 32'h0, 1'b1, 1'b1, 5, 0);
    do_xfer(1'b0, 32'h34, 32'h0, 3, 1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 1'b0, 5, 0);
    do_xfer(1'b1, 32'h40, 32'h55AA_55AA, 0, 1'b0, 32'h2222_2222, 32'h0, 1'b0, 1'b0, 2, 5);
    do_xfer(1'b0, 32'h40, 32'h0, 1, 1'b0, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 1'b0, 3, 0);

    cfg_waits = 100;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h50; cmd_wdata = '0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("in_access", 64'({psel, pen}), 64'(2'b11));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_ctrl", 64'({psel, pen, rsp_valid, cmd_ready}), 64'(4'b0001));
    chk("rst_mid_paddr", 64'(paddr), 64'(0));
    any_valid = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (rsp_valid || psel) any_valid = 1'b1;
    end
    chk("no_rsp_after_rst", 64'(any_valid), 64'(0));

    do_xfer(1'b1, 32'h60, 32'h1357_9BDF, 2, 1'b0, 32'h3333_3333, 32'h0, 1'b0, 1'b0, 4, 0);
    repeat (2) @(posedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
